// File: rtl/ahb_default_slave_pkg.sv
// Shared types and constants for the AHB-Lite default slave.
package ahb_default_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  // Prefixed names keep the state literals distinct from the htrans literals.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2,
    ST_DONE
  } dslv_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // NONSEQ and SEQ are the only transfer types that need a real response.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave_gen_err_log.sv
// Unmapped-access log: saturating counter plus first-fault address/direction.
module default_slave_err_log
  import ahb_default_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  accept,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Clear wins over the old contents, but an accept in the same cycle is still logged.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else if (err_clr) begin
      cnt_q   <= accept ? CNT_WIDTH'(1) : '0;
      valid_q <= accept;
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
      end
    end else if (accept) begin
      cnt_q <= sat_inc(cnt_q);
      if (!valid_q) begin
        valid_q <= 1'b1;
        addr_q  <= haddr;
        write_q <= hwrite;
      end
    end
  end

  assign err_cnt   = cnt_q;
  assign err_valid = valid_q;
  assign err_addr  = addr_q;
  assign err_write = write_q;

endmodule

// File: rtl/ahb_default_slave_gen.sv
// AHB-Lite default slave: configurable wait states, then ERROR or zero-data OKAY.
module ahb_default_slave_gen
  import ahb_default_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ERR_WAIT   = 0,
  parameter int RESP_MODE  = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel,
  input  logic [1:0]            htrans,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  err_clr,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  err_write
);

  localparam logic [3:0] WAIT_LOAD = (ERR_WAIT > 0) ? 4'(ERR_WAIT - 1) : 4'd0;
  localparam dslv_state_t RESP_ST  = (RESP_MODE == 0) ? ST_ERR1 : ST_DONE;
  localparam dslv_state_t START_ST = (ERR_WAIT > 0) ? ST_WAIT : RESP_ST;

  dslv_state_t state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        hreadyout_q;
  logic        hresp_q;
  logic        can_start;
  logic        accept;

  // A new address phase is only taken when the previous data phase is finishing.
  assign can_start = (state_q == ST_IDLE) || (state_q == ST_ERR2) || (state_q == ST_DONE);
  assign accept    = hsel & hready & is_active(htrans) & can_start;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE, ST_ERR2, ST_DONE: begin
        if (accept) begin
          state_d = START_ST;
          wcnt_d  = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = RESP_ST;
        else                wcnt_d  = wcnt_q - 1'b1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM register; outputs are registered from the next state so no input reaches a port.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      wcnt_q      <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      hreadyout_q <= (state_d != ST_WAIT) && (state_d != ST_ERR1);
      hresp_q     <= ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = '0;

  default_slave_err_log #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_err_log (
    .clk      (hclk),
    .rst      (hreset),
    .accept   (accept),
    .haddr    (haddr),
    .hwrite   (hwrite),
    .err_clr  (err_clr),
    .err_cnt  (err_cnt),
    .err_valid(err_valid),
    .err_addr (err_addr),
    .err_write(err_write)
  );

endmodule

// File: doc/ahb_default_slave_gen.md
Name: ahb_default_slave_gen

Overview:
Parametrised AHB-Lite default slave. It answers every transfer the decoder routes to unmapped address space. Active transfers (NONSEQ/SEQ) get a configurable number of wait states, then either the two-cycle ERROR response or a zero-data OKAY. IDLE/BUSY transfers get a zero-wait OKAY. The block also logs unmapped accesses (saturating count, first-fault address and direction) for debug software, and replaces the fixed two-state default slave in generated bus fabrics.

Parameters:
ADDR_WIDTH, 32, width of haddr and err_addr
DATA_WIDTH, 32, width of hrdata
ERR_WAIT, 0, wait cycles (hreadyout=0, hresp=OKAY) inserted before the response; 0..15
RESP_MODE, 0, 0 = ERROR response; 1 = OKAY, read-as-zero/write-ignored
CNT_WIDTH, 8, width of the saturating access counter

Ports:
hclk  in  1  bus clock; all logic on rising edge
hreset  in  1  synchronous reset, active-high
hsel  in  1  slave select from decoder
htrans  in  2  transfer type
haddr  in  ADDR_WIDTH  address
hwrite  in  1  1 = write
hready  in  1  bus-level ready (address phase accepted when 1)
hreadyout  out  1  slave ready
hresp  out  1  0 = OKAY, 1 = ERROR
hrdata  out  DATA_WIDTH  always zero
err_clr  in  1  clears err_cnt and err_valid
err_cnt  out  CNT_WIDTH  unmapped active transfers since reset/clear
err_valid  out  1  err_addr/err_write hold a captured fault
err_addr  out  ADDR_WIDTH  address of first fault since clear
err_write  out  1  direction of first fault

Behaviour:
- Accept = hsel & hready & htrans[1] (NONSEQ or SEQ). hsel & hready with IDLE/BUSY: no state change, OKAY, zero wait.
- States: IDLE, WAIT, ERR1, ERR2, DONE. Outputs decode registered state and wait counter only; no combinational path from inputs to outputs.
- IDLE: hreadyout=1, hresp=0. On accept: go to WAIT if ERR_WAIT>0 (load wait counter with ERR_WAIT-1); else go to ERR1 (RESP_MODE=0) or DONE (RESP_MODE=1).
- WAIT: hreadyout=0, hresp=0. Counter decrements each cycle. At 0, go to ERR1 or DONE per RESP_MODE. Inputs are ignored.
- ERR1: hreadyout=0, hresp=1. Next state is ERR2 unconditionally.
- ERR2: hreadyout=1, hresp=1. DONE: hreadyout=1, hresp=0. Both are data-phase-final cycles. A new accept in this cycle starts the next transfer (WAIT/ERR1/DONE); otherwise go to IDLE. A master cancelling with IDLE during ERR2 causes no new transfer.
- Latency: last data-phase cycle is ERR_WAIT+2 cycles after acceptance (ERROR) or ERR_WAIT+1 cycles after (OKAY).
- hrdata = 0 always. Write data is ignored.
- Logging, on every accept, in both modes:
  - err_cnt increments by 1 and saturates at all-ones.
  - If err_valid=0: capture haddr/hwrite into err_addr/err_write and set err_valid.
- err_clr:
  - Without a coincident accept: err_cnt=0, err_valid=0; err_addr/err_write keep their values.
  - With a coincident accept: err_cnt=1, err_valid=1, new address and direction captured.
- Reset (sync, hreset=1 at an edge) from any state, including mid-WAIT/ERR1: state=IDLE, hreadyout=1, hresp=0, err_cnt=0, err_valid=0, err_addr=0, err_write=0, wait counter=0. Reset takes priority over all inputs.

Decomposition:
- Package ahb_default_slave_pkg:
  - htrans_t enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - dslv_state_t enum: IDLE, WAIT, ERR1, ERR2, DONE.
  - Constants HRESP_OKAY=1'b0, HRESP_ERROR=1'b1.
- One sub-module, default_slave_err_log, containing counter, capture registers and clear priority. Inputs: accept, haddr, hwrite, err_clr. Parameters: ADDR_WIDTH, CNT_WIDTH.
- The top module holds the FSM and wait counter.

Test Plan:
- ERR_WAIT=0, RESP_MODE=0, NONSEQ read haddr=0x4000_0000 -> next cycle hreadyout=0/hresp=1, then hreadyout=1/hresp=1, then IDLE; err_cnt=1, err_valid=1, err_addr=0x4000_0000, err_write=0.
- ERR_WAIT=2, NONSEQ write -> 2 cycles hreadyout=0/hresp=0, then ERR1, ERR2; err_write=1. With RESP_MODE=1 -> 2 wait cycles, then one cycle hreadyout=1/hresp=0, hrdata=0.
- IDLE, BUSY, and NONSEQ with hready=0 or hsel=0 -> hreadyout stays 1, hresp 0, err_cnt unchanged.
- Back-to-back: NONSEQ accepted during ERR2 -> ERR1 on the next cycle with no IDLE gap; err_cnt=2, err_addr still holds the first address.
- CNT_WIDTH=2, 5 accepts -> err_cnt=3 (saturated). err_clr coincident with a 6th accept at 0x10 -> err_cnt=1, err_addr=0x10.
- hreset asserted during ERR1 -> next cycle hreadyout=1, hresp=0, err_cnt=0, err_valid=0; a following NONSEQ is handled normally.
